// File: rtl/mimo_precoder.sv
// mimo_precoder: transmit-side spatial precoder. Multiplies one complex
// layer vector x by the programmable complex matrix W (tx = W * x) for
// 1x1, 2x2, 4x4 or 8x8 configurations, one layer column per cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   mimo_config          00/01/10/11 -> N = 1/2/4/8, sampled at accept
//   cfg_we/row/col/coef  write W[row][col] = {re, im} (IDLE only)
//   cfg_err              one-cycle pulse when a write is dropped (busy)
//   layer_data/valid     input vector, layer k at [k*32 +: 32] = {re, im}
//   layer_ready          high in IDLE
//   tx_data/valid/ready  output vector, antenna a at [a*32 +: 32]
//   busy                 high whenever a vector is in flight
module mimo_precoder #(
  parameter int MAX_ANT = 8,
  parameter int DW      = 16,
  parameter int FRAC    = 14,
  parameter int ACCW    = 36,
  localparam int AW     = $clog2(MAX_ANT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mimo_config,
  input  logic                      cfg_we,
  input  logic [AW-1:0]             cfg_row,
  input  logic [AW-1:0]             cfg_col,
  input  logic [2*DW-1:0]           cfg_coef,
  output logic                      cfg_err,
  input  logic [MAX_ANT*2*DW-1:0]   layer_data,
  input  logic                      layer_valid,
  output logic                      layer_ready,
  output logic [MAX_ANT*2*DW-1:0]   tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUTPUT} state_t;

  localparam logic signed [ACCW-1:0] HALF = ACCW'(1) <<< (FRAC - 1);
  localparam logic signed [ACCW-1:0] MAXV = ACCW'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] MINV = ACCW'(-(2 ** (DW - 1)));
  localparam logic [DW-1:0]          ONE  = DW'(2 ** FRAC);

  state_t                 state;
  logic [2*DW-1:0]        w_mem  [MAX_ANT][MAX_ANT];
  logic signed [DW-1:0]   x_re   [MAX_ANT];
  logic signed [DW-1:0]   x_im   [MAX_ANT];
  logic signed [ACCW-1:0] acc_re [MAX_ANT];
  logic signed [ACCW-1:0] acc_im [MAX_ANT];
  logic [AW-1:0]          k;
  logic [AW-1:0]          n_last;   // N-1 of the vector in flight

  assign layer_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // Full-precision 16x16 signed product, sign-extended to accumulator width.
  function automatic logic signed [ACCW-1:0] prod(input logic signed [DW-1:0] p,
                                                   input logic signed [DW-1:0] q);
    logic signed [2*DW-1:0] t;
    t = (2*DW)'(p) * (2*DW)'(q);
    return ACCW'(t);
  endfunction

  // Round half up by FRAC bits, then saturate to the DW-bit signed range.
  function automatic logic [DW-1:0] round_sat(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] s;
    s = (acc + HALF) >>> FRAC;
    if (s > MAXV)      return MAXV[DW-1:0];
    else if (s < MINV) return MINV[DW-1:0];
    else               return s[DW-1:0];
  endfunction

  // NOTE: all state below is sequential, so every assignment is non-blocking;
  // blocking here would let later statements see same-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      n_last   <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      cfg_err  <= 1'b0;
      for (int a = 0; a < MAX_ANT; a++) begin
        acc_re[a] <= '0;
        acc_im[a] <= '0;
        x_re[a]   <= '0;
        x_im[a]   <= '0;
        // NOTE: the coefficient array is reset on purpose -- the datapath must
        // act as a pass-through (identity) before software programs W.
        for (int c = 0; c < MAX_ANT; c++)
          w_mem[a][c] <= (a == c) ? {ONE, {DW{1'b0}}} : '0;
      end
    end else begin
      cfg_err <= cfg_we && (state != IDLE);
      // A write coinciding with an accept lands before the first MAC cycle.
      if (cfg_we && (state == IDLE))
        w_mem[cfg_row][cfg_col] <= cfg_coef;

      case (state)
        IDLE: begin
          if (layer_valid) begin
            for (int c = 0; c < MAX_ANT; c++) begin
              x_re[c]   <= layer_data[c*2*DW+DW +: DW];
              x_im[c]   <= layer_data[c*2*DW    +: DW];
              acc_re[c] <= '0;
              acc_im[c] <= '0;
            end
            case (mimo_config)
              2'b00:   n_last <= AW'(0);
              2'b01:   n_last <= AW'(1);
              2'b10:   n_last <= AW'(3);
              default: n_last <= AW'(7);
            endcase
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          for (int a = 0; a < MAX_ANT; a++) begin
            acc_re[a] <= acc_re[a]
                       + prod($signed(w_mem[a][k][2*DW-1:DW]), x_re[k])
                       - prod($signed(w_mem[a][k][DW-1:0]),    x_im[k]);
            acc_im[a] <= acc_im[a]
                       + prod($signed(w_mem[a][k][2*DW-1:DW]), x_im[k])
                       + prod($signed(w_mem[a][k][DW-1:0]),    x_re[k]);
          end
          k <= k + AW'(1);
          if (k == n_last) state <= ROUND;
        end
        ROUND: begin
          for (int a = 0; a < MAX_ANT; a++)
            tx_data[a*2*DW +: 2*DW] <= (a <= int'(n_last))
                                     ? {round_sat(acc_re[a]), round_sat(acc_im[a])}
                                     : '0;
          tx_valid <= 1'b1;
          state    <= OUTPUT;
        end
        OUTPUT: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mimo_precoder.sv
// tb_mimo_precoder: directed self-checking bench for mimo_precoder. A
// reference model of W and the complex matrix product produces expected
// output vectors, queued at stimulus time and compared when tx_valid rises.
module tb_mimo_precoder;
  localparam int MAX_ANT = 8;
  localparam int DW      = 16;
  localparam int VW      = MAX_ANT * 2 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mimo_config = 2'b00;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_row = '0;
  logic [2:0]    cfg_col = '0;
  logic [31:0]   cfg_coef = '0;
  logic          cfg_err;
  logic [VW-1:0] layer_data = '0;
  logic          layer_valid = 1'b0;
  logic          layer_ready;
  logic [VW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          busy;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [VW-1:0] sb [$];
  int            wre [MAX_ANT][MAX_ANT];
  int            wim [MAX_ANT][MAX_ANT];
  int            last_n = 1;

  mimo_precoder dut (
    .clk(clk), .rst_n(rst_n), .mimo_config(mimo_config),
    .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_coef(cfg_coef),
    .cfg_err(cfg_err), .layer_data(layer_data), .layer_valid(layer_valid),
    .layer_ready(layer_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cx(input int re, input int im);
    return {16'(re), 16'(im)};
  endfunction

  function automatic logic [15:0] sat(input longint v);
    longint s;
    s = (v + 64'sd8192) >>> 14;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  function automatic logic [VW-1:0] model(input logic [VW-1:0] x, input int n);
    logic [VW-1:0] r;
    longint ar, ai, xr, xi;
    r = '0;
    for (int a = 0; a < n; a++) begin
      ar = 0;
      ai = 0;
      for (int c = 0; c < n; c++) begin
        xr = $signed(x[c*32+16 +: 16]);
        xi = $signed(x[c*32    +: 16]);
        ar += longint'(wre[a][c]) * xr - longint'(wim[a][c]) * xi;
        ai += longint'(wre[a][c]) * xi + longint'(wim[a][c]) * xr;
      end
      r[a*32 +: 32] = {sat(ar), sat(ai)};
    end
    return r;
  endfunction

  function automatic void model_identity();
    for (int a = 0; a < MAX_ANT; a++)
      for (int c = 0; c < MAX_ANT; c++) begin
        wre[a][c] = (a == c) ? 16384 : 0;
        wim[a][c] = 0;
      end
  endfunction

  // Coefficient write while the DUT is idle; called at a falling edge.
  task automatic write_w(input int row, input int col, input int re, input int im);
    cfg_we = 1'b1; cfg_row = 3'(row); cfg_col = 3'(col); cfg_coef = cx(re, im);
    @(negedge clk);
    cfg_we = 1'b0;
    wre[row][col] = re;
    wim[row][col] = im;
    check("cfg_err_idle", VW'(cfg_err), VW'(0));
  endtask

  // Present one vector for one cycle, optionally with a same-cycle write.
  task automatic send(input logic [1:0] cfg, input logic [VW-1:0] data, input bit we,
                      input int row, input int col, input int re, input int im);
    mimo_config = cfg; layer_data = data; layer_valid = 1'b1;
    cfg_we = we; cfg_row = 3'(row); cfg_col = 3'(col); cfg_coef = cx(re, im);
    if (we) begin
      wre[row][col] = re;
      wim[row][col] = im;
    end
    last_n = 1 << cfg;
    sb.push_back(model(data, last_n));
    check("accept_ready", VW'(layer_ready), VW'(1));
    @(negedge clk);
    layer_valid = 1'b0; cfg_we = 1'b0; layer_data = '1;
  endtask

  // Wait for the result, compare, optionally stall, then retire it.
  task automatic collect(input string tag, input int stall);
    int lat;
    logic [VW-1:0] exp, held;
    lat = 0;
    while (tx_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, VW'(lat), VW'(last_n + 1));
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    check({tag, "_data"}, tx_data, exp);
    held = tx_data;
    for (int i = 0; i < stall; i++) begin
      cfg_we = (i == 1); cfg_row = 3'd1; cfg_col = 3'd1; cfg_coef = '0;
      @(negedge clk);
      check({tag, "_stall_data"}, tx_data, held);
      check({tag, "_stall_valid"}, VW'(tx_valid), VW'(1));
      check({tag, "_stall_ready"}, VW'(layer_ready), VW'(0));
      check({tag, "_stall_busy"}, VW'(busy), VW'(1));
      if (i == 1) check({tag, "_cfg_err_pulse"}, VW'(cfg_err), VW'(1));
      if (i == 2) check({tag, "_cfg_err_clear"}, VW'(cfg_err), VW'(0));
    end
    cfg_we = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check({tag, "_retired"}, VW'(tx_valid), VW'(0));
  endtask

  initial begin
    logic [VW-1:0] v;
    model_identity();

    // Reset state.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx_valid", VW'(tx_valid), VW'(0));
    check("rst_tx_data", tx_data, VW'(0));
    check("rst_busy", VW'(busy), VW'(0));
    check("rst_layer_ready", VW'(layer_ready), VW'(1));
    check("rst_cfg_err", VW'(cfg_err), VW'(0));

    // 1: 2x2 identity.
    v = '0; v[0 +: 32] = cx(1000, -500); v[32 +: 32] = cx(200, 300);
    send(2'b01, v, 1'b0, 0, 0, 0, 0);
    collect("s1_identity", 0);

    // 2: W[0][1] = 1.0 adds layer 1 into antenna 0.
    write_w(0, 1, 16384, 0);
    send(2'b01, v, 1'b0, 0, 0, 0, 0);
    collect("s2_mix", 0);

    // 3: 1x1 with W = j.
    write_w(0, 0, 0, 16384);
    v = '0; v[0 +: 32] = cx(1000, 2000);
    send(2'b00, v, 1'b0, 0, 0, 0, 0);
    collect("s3_rotate", 0);

    // 4a: rounding half up, W = 0.5.
    write_w(0, 0, 8192, 0);
    v = '0; v[0 +: 32] = cx(3, -3);
    send(2'b00, v, 1'b0, 0, 0, 0, 0);
    collect("s4_round", 0);

    // 4b: 8x8 all-ones matrix saturates every antenna.
    for (int a = 0; a < MAX_ANT; a++)
      for (int c = 0; c < MAX_ANT; c++)
        write_w(a, c, 16384, 0);
    for (int c = 0; c < MAX_ANT; c++) v[c*32 +: 32] = cx(30000, -30000);
    send(2'b11, v, 1'b0, 0, 0, 0, 0);
    collect("s4_saturate", 0);

    // 5: output stall with a rejected write, then confirm W[1][1] unchanged.
    v = '0; v[0 +: 32] = cx(-1234, 567); v[32 +: 32] = cx(890, -42);
    send(2'b01, v, 1'b0, 0, 0, 0, 0);
    collect("s5_stall", 5);
    send(2'b01, v, 1'b0, 0, 0, 0, 0);
    collect("s5_w_kept", 0);

    // 4x4 random W, same-cycle write at accept, config change ignored.
    for (int a = 0; a < 4; a++)
      for (int c = 0; c < 4; c++)
        write_w(a, c, int'($urandom_range(0, 65535)) - 32768,
                      int'($urandom_range(0, 65535)) - 32768);
    for (int c = 0; c < MAX_ANT; c++)
      v[c*32 +: 32] = cx(int'($urandom_range(0, 65535)) - 32768,
                         int'($urandom_range(0, 65535)) - 32768);
    send(2'b10, v, 1'b1, 3, 2, -20000, 12345);
    mimo_config = 2'b11;
    collect("r4_random", 0);

    // 6: reset during MAC of an 8x8 vector.
    send(2'b11, v, 1'b0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("s6_rst_tx_valid", VW'(tx_valid), VW'(0));
    check("s6_rst_tx_data", tx_data, VW'(0));
    check("s6_rst_busy", VW'(busy), VW'(0));
    sb.delete();
    model_identity();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '0; v[0 +: 32] = cx(1000, -500); v[32 +: 32] = cx(200, 300);
    send(2'b01, v, 1'b0, 0, 0, 0, 0);
    collect("s6_identity", 0);

    check("sb_empty", VW'(sb.size()), VW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mimo_precoder.md
Name: mimo_precoder

Overview:
Transmit-side MIMO spatial precoder for the 5G modem. It takes one complex symbol per spatial layer and multiplies the layer vector by a programmable complex precoding matrix W. The result is one complex sample per transmit antenna, streamed to the per-antenna IFFT/DAC paths. It supports 1x1, 2x2, 4x4 and 8x8 configurations, selected per symbol vector.

Parameters:
MAX_ANT, 8, maximum number of layers/antennas; W is MAX_ANT x MAX_ANT.
DW, 16, signed width of each I or Q component, for samples and coefficients.
FRAC, 14, fractional bits of coefficients (16384 = 1.0).
ACCW, 36, signed accumulator width per I/Q component.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
mimo_config  input  2  00 1x1, 01 2x2, 10 4x4, 11 8x8; N = 1/2/4/8
cfg_we  input  1  coefficient write strobe
cfg_row  input  3  antenna index a of W[a][k]
cfg_col  input  3  layer index k of W[a][k]
cfg_coef  input  2*DW  {re, im} signed coefficient
cfg_err  output  1  one-cycle pulse: write rejected because block busy
layer_data  input  MAX_ANT*2*DW  layer k at bits [k*32 +: 32], {re, im}
layer_valid  input  1  layer vector valid
layer_ready  output  1  block can accept a vector
tx_data  output  MAX_ANT*2*DW  antenna a at bits [a*32 +: 32], {re, im}
tx_valid  output  1  tx_data valid
tx_ready  input  1  downstream accepts tx_data
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous, also mid-operation): state IDLE; tx_data 0; tx_valid 0; cfg_err 0; busy 0; accumulators 0; W = identity (W[a][a] = (16384,0), all others (0,0)). Any in-flight vector is discarded.
- layer_ready = 1 only in IDLE (combinational from state). Accept = layer_valid & layer_ready.
- FSM states IDLE, MAC, ROUND, OUTPUT.
  - IDLE: on accept, latch layer_data and N (from mimo_config), clear accumulators, set k=0, go to MAC.
  - MAC: one layer column per cycle. For every antenna a in parallel, acc[a] += W[a][k]*x[k] (complex multiply-accumulate); k++. After the edge processing k = N-1, go to ROUND.
  - ROUND: at the next edge, register tx_data and set tx_valid=1, then go to OUTPUT.
  - OUTPUT: hold tx_data and tx_valid stable while tx_ready=0. When tx_ready=1, clear tx_valid and go to IDLE.
- Latency: with acceptance at edge t0, tx_valid rises at edge t0+N+1 (1x1: 2 cycles, 8x8: 9 cycles).
- Throughput: at most one vector per N+3 cycles, plus any stall cycles.
- mimo_config is sampled only at accept; changes during MAC/ROUND/OUTPUT are ignored.
- Arithmetic:
  - Complex product re = wr*xr - wi*xi, im = wr*xi + wi*xr. Each term is a full-precision signed 32 bit product; sums are sign-extended to ACCW. No overflow is possible within ACCW for N<=8.
  - Output: (acc + 2^(FRAC-1)) >>> FRAC, arithmetic shift (round half up), then saturate to [-32768, 32767].
- Antennas a >= N output (0,0). Layers k >= N are never read.
- Coefficient write:
  - In IDLE, cfg_we writes W[cfg_row][cfg_col] at the edge.
  - A write in the same cycle as an accept takes effect and is used by that vector.
  - In any other state the write is dropped, W is unchanged, and cfg_err pulses high for one cycle.
  - Indices >= N are legal to write and are stored.

Test Plan:
1. After reset, 2x2 config. Accept L0=(1000,-500), L1=(200,300) -> tx_valid 3 cycles later. ant0=(1000,-500), ant1=(200,300), ants 2-7 = (0,0).
2. Write W[0][1]=(16384,0), then repeat scenario 1 -> ant0=(1200,-200), ant1=(200,300).
3. 1x1 config, W[0][0]=(0,16384) (i.e. j), input (1000,2000) -> ant0=(-2000,1000), tx_valid 2 cycles after accept.
4. 1x1 config, W[0][0]=(8192,0). Input (3,-3) -> (2,-1), checks rounding. Then 8x8 config, all W=(16384,0), all layers (30000,-30000) -> every antenna (32767,-32768), checks saturation.
5. Hold tx_ready=0 for 5 cycles in OUTPUT -> tx_data/tx_valid stable, layer_ready=0. A cfg_we in this window -> cfg_err one-cycle pulse and W unchanged (verified on the next vector).
6. Assert rst_n low during MAC of an 8x8 vector -> tx_valid=0 and tx_data=0 immediately. The next 2x2 vector reproduces the identity result of scenario 1.
